// File: rtl/tusca_escalonador_medidas_if.sv
// Sensor-side and transmitter-side handshake bundle for the measurement scheduler.
// master = scheduler, slave = sensor interface mux / serial transmitter.
interface tusca_escalonador_medidas_if #(
    parameter int N_CANAIS = 2,
    parameter int LARGURA  = 16
);
    logic [N_CANAIS-1:0] medir;
    logic                reset_sensor;
    logic                pronto_medida;
    logic                erro_medida;
    logic [LARGURA-1:0]  temperatura;
    logic [LARGURA-1:0]  umidade;
    logic                transmite;
    logic                pronto_transmissao;

    modport master (
        output medir, reset_sensor, transmite,
        input  pronto_medida, erro_medida, temperatura, umidade, pronto_transmissao
    );

    modport slave (
        input  medir, reset_sensor, transmite,
        output pronto_medida, erro_medida, temperatura, umidade, pronto_transmissao
    );
endinterface

// File: rtl/tusca_escalonador_medidas.sv
// Round-robin multi-sensor measurement scheduler with timeout, bounded retry and level classification.
// Optional level-drop hysteresis enabled by defining TUSCA_HISTERESE_EN.
//
// state     | meaning
// INICIAL   | idle, waiting for start
// ESPERA    | period delay between rounds
// MEDIR     | one-cycle start pulse to the selected sensor
// AGUARDA   | waiting for pronto/erro, timeout running
// ARMAZENA  | write captured reading into channel slot
// ERRO      | count attempt, retry or flag falha
// RESETA    | one-cycle reset pulse to the selected sensor
// TRANSMITE | request held until transmitter ack
// PROXIMO   | channel boundary: stop, wrap or advance
module tusca_escalonador_medidas #(
    parameter int N_CANAIS       = 2,
    parameter int LARGURA        = 16,
    parameter int PERIODO_DELAY  = 100_000_000,
    parameter int TIMEOUT        = 50_000_000,
    parameter int MAX_TENTATIVAS = 3,
    parameter int HISTERESE      = 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      parar,
    tusca_escalonador_medidas_if.master               bus,
    input  logic [4*LARGURA-1:0]                      lim_temp,
    output logic [$clog2(N_CANAIS > 1 ? N_CANAIS : 2)-1:0] canal,
    output logic [N_CANAIS*LARGURA-1:0]               temp_valida,
    output logic [N_CANAIS*LARGURA-1:0]               umid_valida,
    output logic [3*N_CANAIS-1:0]                     nivel,
    output logic [N_CANAIS-1:0]                       falha,
    output logic                                      ativo,
    output logic [3:0]                                db_estado
);
    localparam int CW      = $clog2(N_CANAIS > 1 ? N_CANAIS : 2);
    localparam int CNT_MAX = (PERIODO_DELAY > TIMEOUT) ? PERIODO_DELAY : TIMEOUT;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(MAX_TENTATIVAS + 1);
`ifdef TUSCA_HISTERESE_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        MEDIR     = 4'd2,
        AGUARDA   = 4'd3,
        ARMAZENA  = 4'd4,
        ERRO      = 4'd5,
        RESETA    = 4'd6,
        TRANSMITE = 4'd7,
        PROXIMO   = 4'd8
    } estado_t;

    estado_t            estado, prox_estado;
    logic [CNTW-1:0]    cont;
    logic [TW-1:0]      tent;
    logic [TW-1:0]      tent_prox;
    logic               parar_pend;
    logic               parar_vis;
    logic               ultimo_canal;
    logic [LARGURA-1:0] temp_cap, umid_cap;
    logic [2:0]         nivel_atual, nivel_lim, nivel_novo;
    logic [LARGURA-1:0] lim_k, limiar_queda;

    function automatic logic [2:0] nivel_limiar(input logic [LARGURA-1:0] t,
                                                input logic [4*LARGURA-1:0] lim);
        if (t < lim[LARGURA-1:0])                 return 3'd0;
        else if (t < lim[2*LARGURA-1:LARGURA])    return 3'd1;
        else if (t < lim[3*LARGURA-1:2*LARGURA])  return 3'd2;
        else if (t < lim[4*LARGURA-1:3*LARGURA])  return 3'd3;
        else                                      return 3'd4;
    endfunction

    assign tent_prox    = tent + TW'(1);
    assign parar_vis    = parar | parar_pend;
    assign ultimo_canal = (canal == CW'(N_CANAIS - 1));
    assign nivel_atual  = nivel[canal*3 +: 3];
    assign nivel_lim    = nivel_limiar(temp_cap, lim_temp);

    // A drop below the current level walks down one step at a time, each step needing the margin.
    always_comb begin
        nivel_novo   = nivel_lim;
        lim_k        = '0;
        limiar_queda = '0;
        if (HIST_EN && (nivel_lim < nivel_atual)) begin
            nivel_novo = nivel_atual;
            for (int k = 4; k >= 1; k--) begin
                lim_k        = lim_temp[(k-1)*LARGURA +: LARGURA];
                limiar_queda = (lim_k > LARGURA'(HISTERESE)) ? lim_k - LARGURA'(HISTERESE) : '0;
                if ((nivel_novo == 3'(k)) && (3'(k) > nivel_lim) && (temp_cap < limiar_queda))
                    nivel_novo = 3'(k - 1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado      = estado;
        bus.medir        = '0;
        bus.reset_sensor = 1'b0;
        bus.transmite    = 1'b0;
        ativo            = (estado != INICIAL);
        db_estado        = estado;
        case (estado)
            INICIAL:   if (start) prox_estado = ESPERA;
            ESPERA: begin
                if (parar_vis)           prox_estado = INICIAL;
                else if (cont == '0)     prox_estado = MEDIR;
            end
            MEDIR: begin
                bus.medir   = N_CANAIS'(1) << canal;
                prox_estado = AGUARDA;
            end
            AGUARDA: begin
                if (bus.erro_medida)        prox_estado = ERRO;
                else if (bus.pronto_medida) prox_estado = ARMAZENA;
                else if (cont == '0)        prox_estado = ERRO;
            end
            ARMAZENA:  prox_estado = TRANSMITE;
            ERRO:      prox_estado = (tent_prox < TW'(MAX_TENTATIVAS)) ? RESETA : PROXIMO;
            RESETA: begin
                bus.reset_sensor = 1'b1;
                prox_estado      = MEDIR;
            end
            TRANSMITE: begin
                bus.transmite = 1'b1;
                if (bus.pronto_transmissao) prox_estado = PROXIMO;
            end
            PROXIMO: begin
                if (parar_vis)         prox_estado = INICIAL;
                else if (ultimo_canal) prox_estado = ESPERA;
                else                   prox_estado = MEDIR;
            end
            default:   prox_estado = INICIAL;
        endcase
    end

    // Shared down-counter: period delay in ESPERA, timeout in AGUARDA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cont <= '0;
        else if ((estado != ESPERA) && (prox_estado == ESPERA))
            cont <= CNTW'(PERIODO_DELAY - 1);
        else if (estado == MEDIR)
            cont <= CNTW'(TIMEOUT - 1);
        else if (estado == INICIAL)
            cont <= '0;
        else if (((estado == ESPERA) || (estado == AGUARDA)) && (cont != '0))
            cont <= cont - CNTW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            canal       <= '0;
            tent        <= '0;
            parar_pend  <= 1'b0;
            temp_cap    <= '0;
            umid_cap    <= '0;
            temp_valida <= '0;
            umid_valida <= '0;
            nivel       <= '0;
            falha       <= '0;
        end else begin
            if ((estado == INICIAL) || (estado == PROXIMO)) parar_pend <= 1'b0;
            else if (parar)                                  parar_pend <= 1'b1;

            case (estado)
                INICIAL: begin
                    tent <= '0;
                    if (start) canal <= '0;
                end
                AGUARDA: begin
                    if (prox_estado == ARMAZENA) begin
                        temp_cap <= bus.temperatura;
                        umid_cap <= bus.umidade;
                    end
                end
                ARMAZENA: begin
                    temp_valida[canal*LARGURA +: LARGURA] <= temp_cap;
                    umid_valida[canal*LARGURA +: LARGURA] <= umid_cap;
                    nivel[canal*3 +: 3]                   <= nivel_novo;
                    falha[canal]                          <= 1'b0;
                    tent                                  <= '0;
                end
                ERRO: begin
                    tent <= tent_prox;
                    if (!(tent_prox < TW'(MAX_TENTATIVAS))) falha[canal] <= 1'b1;
                end
                PROXIMO: begin
                    tent <= '0;
                    if (prox_estado == ESPERA)     canal <= '0;
                    else if (prox_estado == MEDIR) canal <= canal + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tusca_escalonador_medidas.sv
// Directed bench for tusca_escalonador_medidas: 2 channels, short delay/timeout, 2 attempts, limits 20/25/30/35.
module tb_tusca_escalonador_medidas;
    localparam int L = 16;
    localparam logic [3:0] S_INICIAL = 4'd0, S_ESPERA = 4'd1, S_MEDIR = 4'd2, S_AGUARDA = 4'd3,
                           S_ARMAZENA = 4'd4, S_ERRO = 4'd5, S_RESETA = 4'd6, S_TRANSMITE = 4'd7,
                           S_PROXIMO = 4'd8;
`ifdef TUSCA_HISTERESE_EN
    localparam logic [2:0] NIV_29_DE_3 = 3'd3;
`else
    localparam logic [2:0] NIV_29_DE_3 = 3'd2;
`endif

    logic           clock = 1'b0;
    logic           reset, start, parar;
    logic [4*L-1:0] lim_temp;
    logic [0:0]     canal;
    logic [2*L-1:0] temp_valida, umid_valida;
    logic [5:0]     nivel;
    logic [1:0]     falha;
    logic           ativo;
    logic [3:0]     db_estado;
    int             erros = 0;
    int             checks = 0;
    int             n;
    logic [1:0]     medir_visto;

    tusca_escalonador_medidas_if #(.N_CANAIS(2), .LARGURA(L)) bus ();

    tusca_escalonador_medidas #(
        .N_CANAIS(2), .LARGURA(L), .PERIODO_DELAY(10), .TIMEOUT(20),
        .MAX_TENTATIVAS(2), .HISTERESE(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .parar(parar), .bus(bus),
        .lim_temp(lim_temp), .canal(canal), .temp_valida(temp_valida),
        .umid_valida(umid_valida), .nivel(nivel), .falha(falha), .ativo(ativo),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic espera_estado(input logic [3:0] s, input string tag);
        int k = 0;
        while ((db_estado != s) && (k < 300)) begin
            @(negedge clock);
            k++;
        end
        if (db_estado != s) verifica(tag, 64'(db_estado), 64'(s));
    endtask

    task automatic conta_estado(input logic [3:0] s, output int cnt);
        cnt = 0;
        while ((db_estado == s) && (cnt < 100)) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    task automatic mede(input logic [15:0] t, input logic [15:0] u);
        espera_estado(S_AGUARDA, "mede_aguarda");
        bus.temperatura   = t;
        bus.umidade       = u;
        bus.pronto_medida = 1'b1;
        @(negedge clock);
        bus.pronto_medida = 1'b0;
    endtask

    task automatic confirma_tx(input string tag);
        espera_estado(S_TRANSMITE, tag);
        verifica({tag, "_tx"}, 64'(bus.transmite), 64'd1);
        repeat (2) @(negedge clock);
        verifica({tag, "_tx_mantido"}, 64'(bus.transmite), 64'd1);
        bus.pronto_transmissao = 1'b1;
        @(negedge clock);
        bus.pronto_transmissao = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; parar = 1'b0;
        lim_temp = {16'd35, 16'd30, 16'd25, 16'd20};
        bus.pronto_medida = 1'b0; bus.erro_medida = 1'b0;
        bus.temperatura = '0; bus.umidade = '0; bus.pronto_transmissao = 1'b0;
        repeat (3) @(negedge clock);
        verifica("rst_estado", 64'(db_estado), 64'(S_INICIAL));
        verifica("rst_ativo", 64'(ativo), 64'd0);
        verifica("rst_canal", 64'(canal), 64'd0);
        verifica("rst_temp", 64'(temp_valida), 64'd0);
        verifica("rst_saidas", {bus.medir, bus.transmite, bus.reset_sensor, falha, nivel}, 64'd0);

        // Round 1: both channels valid
        reset = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        verifica("r1_espera", 64'(db_estado), 64'(S_ESPERA));
        verifica("r1_ativo", 64'(ativo), 64'd1);
        conta_estado(S_ESPERA, n);
        verifica("r1_ciclos_espera", 64'(n), 64'd10);
        verifica("r1_medir0", 64'(bus.medir), 64'b01);
        mede(16'd27, 16'd60);
        verifica("r1_armazena", 64'(db_estado), 64'(S_ARMAZENA));
        verifica("r1_temp0_latencia", 64'(temp_valida[15:0]), 64'd0);
        @(negedge clock);
        verifica("r1_temp0", 64'(temp_valida[15:0]), 64'd27);
        verifica("r1_umid0", 64'(umid_valida[15:0]), 64'd60);
        verifica("r1_nivel0", 64'(nivel[2:0]), 64'd2);
        confirma_tx("r1_ch0");
        verifica("r1_proximo", 64'(db_estado), 64'(S_PROXIMO));
        @(negedge clock);
        verifica("r1_medir1", 64'(bus.medir), 64'b10);
        verifica("r1_canal1", 64'(canal), 64'd1);
        mede(16'd19, 16'd40);
        @(negedge clock);
        verifica("r1_temp1", 64'(temp_valida[31:16]), 64'd19);
        verifica("r1_nivel1", 64'(nivel[5:3]), 64'd0);
        bus.pronto_transmissao = 1'b1;
        @(negedge clock);
        bus.pronto_transmissao = 1'b0;
        verifica("r1_ack_entrada", 64'(db_estado), 64'(S_PROXIMO));
        @(negedge clock);
        verifica("r1_volta_espera", 64'(db_estado), 64'(S_ESPERA));
        verifica("r1_canal_wrap", 64'(canal), 64'd0);
        conta_estado(S_ESPERA, n);
        verifica("r2_ciclos_espera", 64'(n), 64'd10);

        // Round 2: ch0 silent twice, ch1 valid
        @(negedge clock);
        conta_estado(S_AGUARDA, n);
        verifica("r2_timeout1", 64'(n), 64'd20);
        verifica("r2_erro", 64'(db_estado), 64'(S_ERRO));
        @(negedge clock);
        verifica("r2_reset_sensor", {60'd0, bus.reset_sensor, db_estado[2:0]}, {60'd0, 1'b1, 3'd6});
        @(negedge clock);
        verifica("r2_remedir0", 64'(bus.medir), 64'b01);
        @(negedge clock);
        conta_estado(S_AGUARDA, n);
        verifica("r2_timeout2", 64'(n), 64'd20);
        @(negedge clock);
        verifica("r2_proximo", 64'(db_estado), 64'(S_PROXIMO));
        verifica("r2_falha", 64'(falha), 64'b01);
        verifica("r2_temp0_mantida", 64'(temp_valida[15:0]), 64'd27);
        verifica("r2_sem_tx", 64'(bus.transmite), 64'd0);
        @(negedge clock);
        verifica("r2_canal1", 64'(canal), 64'd1);
        mede(16'd31, 16'd50);
        @(negedge clock);
        verifica("r2_nivel1", 64'(nivel[5:3]), 64'd3);
        confirma_tx("r2_ch1");

        // Round 3: erro and pronto together on ch0, then a clean retry
        espera_estado(S_AGUARDA, "r3_aguarda");
        verifica("r3_canal0", 64'(canal), 64'd0);
        bus.temperatura = 16'd99;
        bus.erro_medida = 1'b1;
        bus.pronto_medida = 1'b1;
        @(negedge clock);
        bus.erro_medida = 1'b0;
        bus.pronto_medida = 1'b0;
        verifica("r3_erro_vence", 64'(db_estado), 64'(S_ERRO));
        repeat (2) @(negedge clock);
        mede(16'd29, 16'd55);
        verifica("r3_temp0_inalterada", 64'(temp_valida[15:0]), 64'd27);
        @(negedge clock);
        verifica("r3_temp0", 64'(temp_valida[15:0]), 64'd29);
        verifica("r3_falha_limpa", 64'(falha), 64'b00);
        verifica("r3_nivel0", 64'(nivel[2:0]), 64'd2);
        confirma_tx("r3_ch0");
        mede(16'd29, 16'd45);
        @(negedge clock);
        verifica("r3_nivel1_queda", 64'(nivel[5:3]), 64'(NIV_29_DE_3));
        confirma_tx("r3_ch1");

        // Round 4: parar during ch0, pronto on the timeout cycle
        espera_estado(S_AGUARDA, "r4_aguarda");
        verifica("r4_canal0", 64'(canal), 64'd0);
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        repeat (18) @(negedge clock);
        verifica("r4_aguarda_20", 64'(db_estado), 64'(S_AGUARDA));
        bus.temperatura = 16'd21;
        bus.umidade = 16'd33;
        bus.pronto_medida = 1'b1;
        @(negedge clock);
        bus.pronto_medida = 1'b0;
        verifica("r4_pronto_vence", 64'(db_estado), 64'(S_ARMAZENA));
        @(negedge clock);
        verifica("r4_nivel0", 64'(nivel[2:0]), 64'd1);
        confirma_tx("r4_ch0");
        @(negedge clock);
        verifica("r4_parou", 64'(db_estado), 64'(S_INICIAL));
        verifica("r4_inativo", 64'(ativo), 64'd0);
        medir_visto = '0;
        repeat (20) begin
            medir_visto = medir_visto | bus.medir;
            @(negedge clock);
        end
        verifica("r4_sem_medir1", 64'(medir_visto), 64'd0);

        // Round 5: start ignored while active, async reset in TRANSMITE
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        verifica("r5_espera", 64'(db_estado), 64'(S_ESPERA));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        verifica("r5_start_ignorado", 64'(db_estado), 64'(S_ESPERA));
        mede(16'd27, 16'd60);
        @(negedge clock);
        verifica("r5_transmite", 64'(bus.transmite), 64'd1);
        #2 reset = 1'b1;
        #1;
        verifica("r5_rst_tx", 64'(bus.transmite), 64'd0);
        verifica("r5_rst_estado", 64'(db_estado), 64'(S_INICIAL));
        verifica("r5_rst_ativo", 64'(ativo), 64'd0);
        verifica("r5_rst_dados", {temp_valida, umid_valida}, 64'd0);
        verifica("r5_rst_nivel", {falha, nivel, canal}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end
endmodule
